// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter: clear > load > enable, programmable modulus, wrap or saturate.
// One-cycle latency from inputs to count/ovf; tc is combinational from count and up; no backpressure.
module sync_updown_counter #(
  parameter int N        = 4,
  parameter int MODULUS  = 2 ** N,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  if (N < 1 || MODULUS < 2 || MODULUS > (1 << N)) begin : g_bad_param
    $error("sync_updown_counter: need N >= 1 and 2 <= MODULUS <= 2**N");
  end

  // Top of range held at width N so a full-range modulus compares without an extra bit.
  localparam logic [N-1:0] MAX  = N'(MODULUS - 1);
  localparam logic [N-1:0] ZERO = '0;

  logic         at_max;
  logic         at_zero;
  logic [N-1:0] load_clamped;

  assign at_max       = (count == MAX);
  assign at_zero      = (count == ZERO);
  assign load_clamped = (load_val > MAX) ? MAX : load_val;
  assign tc           = up ? at_max : at_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ovf   <= 1'b0;
    end else if (en && up) begin
      ovf   <= at_max;
      count <= at_max ? (SATURATE ? MAX : ZERO) : count + 1'b1;
    end else if (en) begin
      ovf   <= at_zero;
      count <= at_zero ? (SATURATE ? ZERO : MAX) : count - 1'b1;
    end else begin
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: three instances (mod-10 wrap, mod-10 saturate, mod-16 wrap)
// share one stimulus stream and are checked every cycle against a modular-arithmetic model.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       up = 1'b1;

  logic [3:0] cnt_w, cnt_s, cnt_f;
  logic       tc_w, tc_s, tc_f;
  logic       ovf_w, ovf_s, ovf_f;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_w), .tc(tc_w), .ovf(ovf_w));

  sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_s), .tc(tc_s), .ovf(ovf_s));

  sync_updown_counter #(.N(4), .MODULUS(16), .SATURATE(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_f), .tc(tc_f), .ovf(ovf_f));

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: index 0 = mod-10 wrap, 1 = mod-10 saturate, 2 = mod-16 wrap
  int mod_m [3] = '{10, 10, 16};
  bit sat_m [3] = '{1'b0, 1'b1, 1'b0};
  int mc [3]    = '{0, 0, 0};
  bit mo [3]    = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clr) begin
        mc[k] <= 0;
        mo[k] <= 1'b0;
      end else if (load) begin
        mc[k] <= (int'(load_val) < mod_m[k]) ? int'(load_val) : mod_m[k] - 1;
        mo[k] <= 1'b0;
      end else if (en && up) begin
        mo[k] <= (mc[k] + 1 >= mod_m[k]);
        mc[k] <= sat_m[k] ? ((mc[k] + 1 < mod_m[k]) ? mc[k] + 1 : mod_m[k] - 1)
                          : (mc[k] + 1) % mod_m[k];
      end else if (en) begin
        mo[k] <= (mc[k] - 1 < 0);
        mc[k] <= sat_m[k] ? ((mc[k] > 0) ? mc[k] - 1 : 0)
                          : (mc[k] - 1 + mod_m[k]) % mod_m[k];
      end else begin
        mo[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic bit model_tc(input int k);
    return up ? (mc[k] == mod_m[k] - 1) : (mc[k] == 0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_cnt_w", 32'(cnt_w), 32'(mc[0]));
      check("cmp_ovf_w", 32'(ovf_w), 32'(mo[0]));
      check("cmp_tc_w",  32'(tc_w),  32'(model_tc(0)));
      check("cmp_cnt_s", 32'(cnt_s), 32'(mc[1]));
      check("cmp_ovf_s", 32'(ovf_s), 32'(mo[1]));
      check("cmp_tc_s",  32'(tc_s),  32'(model_tc(1)));
      check("cmp_cnt_f", 32'(cnt_f), 32'(mc[2]));
      check("cmp_ovf_f", 32'(ovf_f), 32'(mo[2]));
      check("cmp_tc_f",  32'(tc_f),  32'(model_tc(2)));
      check("range_w",   32'(cnt_w < 4'd10), 32'd1);
      check("range_s",   32'(cnt_s < 4'd10), 32'd1);
    end
  end

  // Drive inputs now (3 ns after an edge), then wait for the next edge plus 3 ns.
  task automatic apply(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
    clr = c; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    #3;
  endtask

  int pulses;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_cnt_w", 32'(cnt_w), 32'd0);
    check("rst_ovf_w", 32'(ovf_w), 32'd0);
    check("rst_cnt_f", 32'(cnt_f), 32'd0);
    @(posedge clk); #3;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // 1. reset mid-count
    for (int i = 0; i < 7; i++) apply(0, 0, 0, 1, 1);
    check("t1_cnt_7", 32'(cnt_w), 32'd7);
    rst_n = 1'b0;
    #1;
    check("t1_async_cnt", 32'(cnt_w), 32'd0);
    check("t1_async_ovf", 32'(ovf_w), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 0, 1, 1);
      check("t1_after_release", 32'(cnt_w), 32'(i));
    end

    // 2. up wrap
    apply(1, 0, 0, 0, 1);
    for (int i = 1; i <= 11; i++) begin
      apply(0, 0, 0, 1, 1);
      check("t2_cnt", 32'(cnt_w), 32'(i % 10));
      check("t2_ovf", 32'(ovf_w), 32'(i == 10));
      check("t2_tc",  32'(tc_w),  32'(i == 9));
    end

    // 3. down wrap / saturate from 0
    apply(1, 0, 0, 0, 0);
    check("t3_tc_s_idle", 32'(tc_s), 32'd1);
    apply(0, 0, 0, 1, 0);
    check("t3_w_cnt9", 32'(cnt_w), 32'd9);
    check("t3_w_ovf1", 32'(ovf_w), 32'd1);
    check("t3_s_cnt0", 32'(cnt_s), 32'd0);
    check("t3_s_ovf1", 32'(ovf_s), 32'd1);
    check("t3_f_cnt15", 32'(cnt_f), 32'd15);
    apply(0, 0, 0, 1, 0);
    check("t3_w_cnt8", 32'(cnt_w), 32'd8);
    check("t3_w_ovf0", 32'(ovf_w), 32'd0);
    check("t3_s_cnt0b", 32'(cnt_s), 32'd0);
    check("t3_s_ovf1b", 32'(ovf_s), 32'd1);
    check("t3_s_tc", 32'(tc_s), 32'd1);

    // 4. priority and load clamp
    apply(1, 1, 5, 1, 1);
    check("t4_clr_wins", 32'(cnt_w), 32'd0);
    apply(0, 1, 5, 1, 1);
    check("t4_load5", 32'(cnt_w), 32'd5);
    apply(0, 1, 13, 1, 1);
    check("t4_clamp_w", 32'(cnt_w), 32'd9);
    check("t4_noclamp_f", 32'(cnt_f), 32'd13);
    check("t4_ovf_w", 32'(ovf_w), 32'd0);

    // 5. enable / direction
    apply(0, 1, 3, 0, 1);
    apply(0, 0, 0, 1, 1);
    check("t5_en1", 32'(cnt_w), 32'd4);
    apply(0, 0, 0, 0, 1);
    check("t5_en0", 32'(cnt_w), 32'd4);
    apply(0, 0, 0, 1, 1);
    check("t5_en1b", 32'(cnt_w), 32'd5);
    apply(0, 1, 9, 0, 1);
    check("t5_tc_up", 32'(tc_w), 32'd1);
    up = 1'b0;
    #1;
    check("t5_tc_flip", 32'(tc_w), 32'd0);
    apply(0, 0, 0, 1, 0);
    check("t5_down8", 32'(cnt_w), 32'd8);

    // 6. full range on the mod-16 instance
    apply(1, 0, 0, 0, 1);
    pulses = 0;
    for (int i = 1; i <= 17; i++) begin
      apply(0, 0, 0, 1, 1);
      check("t6_cnt_f", 32'(cnt_f), 32'(i % 16));
      if (ovf_f) pulses++;
    end
    check("t6_ovf_pulses", 32'(pulses), 32'd1);

    for (int i = 0; i < 10000; i++) begin
      apply(($urandom_range(15) == 0), ($urandom_range(7) == 0),
            4'($urandom_range(15)), ($urandom_range(3) != 0), 1'($urandom_range(1)));
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
